// File: rtl/cpu_arith_seq.sv
// Registered WIDTH-bit ALU with iterative unsigned multiply/divide behind a Start/Busy/Done handshake.
// Define CPU_ARITH_SEQ_DIV_EN to build the restoring divider (task 11); otherwise task 11 is pass A.
module cpu_arith_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       Task,
   input  logic             Carry_In,
   input  logic             Zero_In,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_High,
   output logic             Carry,
   output logic             Zero,
   output logic             Div_Zero
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StIter, StFinish} state_e;
   typedef enum logic [1:0] {OpSingle, OpMul, OpDiv} op_e;

   state_e            state_q;
   op_e               op_q;
   logic [WIDTH-1:0]  hi_q, lo_q, opnd_q;
   logic [CntW-1:0]   cnt_q;
   logic              res_c_q, res_z_q, res_dz_q;

   logic              is_mul, is_div, is_pass, add_sub, cin;
   logic [WIDTH-1:0]  bop, sc_y;
   logic [WIDTH:0]    sum, mul_sum;
   logic              sc_c, sc_z;

   assign is_mul = (Task == 5'h10);
`ifdef CPU_ARITH_SEQ_DIV_EN
   assign is_div = (Task == 5'h11);
`else
   assign is_div = 1'b0;
`endif

   // One adder serves ADC/ADD/SBC/SUB: carry = carry-out of A + B' + c.
   always_comb begin
      add_sub = (Task == 5'h07) || (Task == 5'h08);
      bop     = add_sub ? ~B : B;
      cin     = ((Task == 5'h01) || (Task == 5'h07)) ? Carry_In : (Task == 5'h08);
      sum     = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
      is_pass = (Task == 5'h00) || (Task >= 5'h10);
      sc_y    = A;
      sc_c    = Carry;
      unique case (Task)
         5'h01, 5'h02, 5'h07, 5'h08: begin
            sc_y = sum[WIDTH-1:0];
            sc_c = sum[WIDTH];
         end
         5'h03: sc_y = A & B;
         5'h04: sc_y = ~A + {{(WIDTH-1){1'b0}}, 1'b1};
         5'h05: sc_y = ~A;
         5'h06: sc_y = A | B;
         5'h09: sc_y = A ^ B;
         5'h0A: begin
            sc_y = {A[WIDTH-2:0], Carry_In};
            sc_c = A[WIDTH-1];
         end
         5'h0B: begin
            sc_y = {Carry_In, A[WIDTH-1:1]};
            sc_c = A[0];
         end
         5'h0C: sc_y = {A[WIDTH-2:0], A[WIDTH-1]};
         5'h0D: sc_y = {A[0], A[WIDTH-1:1]};
         5'h0E: sc_y = {A[WIDTH-2:0], Carry_In};
         5'h0F: sc_y = {Carry_In, A[WIDTH-1:1]};
         default: sc_y = A;
      endcase
      sc_z = is_pass ? Zero_In : (sc_y == '0);
   end

   // Shift-add step: hi accumulates, lo holds the remaining multiplier bits.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef CPU_ARITH_SEQ_DIV_EN
   logic [WIDTH:0] div_t, div_r;
   logic           div_ge;
   assign div_t  = {hi_q, lo_q[WIDTH-1]};
   assign div_ge = (div_t >= {1'b0, opnd_q});
   assign div_r  = div_t - {1'b0, opnd_q};
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         op_q     <= OpSingle;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         res_c_q  <= 1'b0;
         res_z_q  <= 1'b0;
         res_dz_q <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Y        <= '0;
         Y_High   <= '0;
         Carry    <= 1'b0;
         Zero     <= 1'b0;
         Div_Zero <= 1'b0;
      end else begin
         Done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Done still high means the previous result is being consumed this cycle.
               if (Start && !Done) begin
                  Busy     <= 1'b1;
                  cnt_q    <= '0;
                  res_dz_q <= 1'b0;
                  if (is_mul) begin
                     op_q    <= OpMul;
                     hi_q    <= '0;
                     lo_q    <= B;
                     opnd_q  <= A;
                     state_q <= StIter;
                  end else if (is_div && (B != '0)) begin
                     op_q    <= OpDiv;
                     hi_q    <= '0;
                     lo_q    <= A;
                     opnd_q  <= B;
                     state_q <= StIter;
                  end else if (is_div) begin
                     op_q     <= OpSingle;
                     hi_q     <= A;
                     lo_q     <= '1;
                     res_c_q  <= 1'b0;
                     res_z_q  <= 1'b0;
                     res_dz_q <= 1'b1;
                     state_q  <= StFinish;
                  end else begin
                     op_q    <= OpSingle;
                     hi_q    <= '0;
                     lo_q    <= sc_y;
                     res_c_q <= sc_c;
                     res_z_q <= sc_z;
                     state_q <= StFinish;
                  end
               end
            end
            StIter: begin
               if (op_q == OpMul) begin
                  hi_q <= mul_sum[WIDTH:1];
                  lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
               end else begin
`ifdef CPU_ARITH_SEQ_DIV_EN
                  hi_q <= div_ge ? div_r[WIDTH-1:0] : div_t[WIDTH-1:0];
                  lo_q <= {lo_q[WIDTH-2:0], div_ge};
`endif
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFinish;
            end
            StFinish: begin
               Done    <= 1'b1;
               Busy    <= 1'b0;
               Y       <= lo_q;
               Y_High  <= hi_q;
               state_q <= StIdle;
               unique case (op_q)
                  OpMul: begin
                     Carry    <= |hi_q;
                     Zero     <= (hi_q == '0) && (lo_q == '0);
                     Div_Zero <= 1'b0;
                  end
                  OpDiv: begin
                     Carry    <= 1'b0;
                     Zero     <= (lo_q == '0);
                     Div_Zero <= 1'b0;
                  end
                  default: begin
                     Carry    <= res_c_q;
                     Zero     <= res_z_q;
                     Div_Zero <= res_dz_q;
                  end
               endcase
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_arith_seq.sv
// Directed bench for cpu_arith_seq at WIDTH=8: latency, flags, handshake and reset abort.
module tb_cpu_arith_seq;

   localparam int unsigned W = 8;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic [4:0]   Task = '0;
   logic         Carry_In = 1'b0, Zero_In = 1'b0;
   logic         Busy, Done, Carry, Zero, Div_Zero;
   logic [W-1:0] Y, Y_High;

   int n_checks = 0;
   int n_pass   = 0;
   int lat;
   int n_done;

   cpu_arith_seq #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Task(Task),
      .Carry_In(Carry_In), .Zero_In(Zero_In), .Busy(Busy), .Done(Done), .Y(Y),
      .Y_High(Y_High), .Carry(Carry), .Zero(Zero), .Div_Zero(Div_Zero)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Present a request across exactly one rising edge; returns at the following falling edge.
   task automatic start_op(input logic [4:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic zi);
      @(negedge Clk);
      Task = t; A = a; B = b; Carry_In = ci; Zero_In = zi; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   // Counts rising edges from the accepting edge until Done is seen, bounded.
   task automatic wait_done(output int l);
      l = 0;
      while (!Done && l < 100) begin
         l++;
         @(negedge Clk);
      end
   endtask

   task automatic run_op(input logic [4:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic zi, output int l);
      start_op(t, a, b, ci, zi);
      wait_done(l);
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clk);
         if (Done) n++;
      end
   endtask

   initial begin
      #2;
      check_eq("rst_y", Y, 0);
      check_eq("rst_flags", {Busy, Done, Carry, Zero, Div_Zero}, 0);
      check_eq("rst_yh", Y_High, 0);
      @(negedge Clk);
      Reset = 1'b0;

      run_op(5'h02, 8'hFF, 8'h01, 1'b0, 1'b0, lat);
      check_eq("add_lat", lat, 1);
      check_eq("add_y", Y, 8'h00);
      check_eq("add_cz", {Carry, Zero}, 2'b11);
      check_eq("add_yh", Y_High, 0);
      // Start while Done is high must be dropped.
      Task = 5'h02; A = 8'h01; B = 8'h01; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check_eq("done_start_ign", {Busy, Done}, 2'b00);
      check_eq("done_start_y", Y, 8'h00);

      run_op(5'h07, 8'h10, 8'h01, 1'b0, 1'b0, lat);
      check_eq("sbc_y", Y, 8'h0E);
      check_eq("sbc_cz", {Carry, Zero}, 2'b10);
      run_op(5'h08, 8'h01, 8'h02, 1'b1, 1'b0, lat);
      check_eq("sub_y", Y, 8'hFF);
      check_eq("sub_cz", {Carry, Zero}, 2'b00);

      // MUL with a second Start pulsed while busy.
      start_op(5'h10, 8'hFF, 8'hFF, 1'b0, 1'b0);
      check_eq("mul_busy", {Busy, Done}, 2'b10);
      @(negedge Clk);
      Task = 5'h02; A = 8'h01; B = 8'h01; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      wait_done(lat);
      check_eq("mul_lat", lat + 2, 9);
      check_eq("mul_y", Y, 8'h01);
      check_eq("mul_yh", Y_High, 8'hFE);
      check_eq("mul_cz", {Carry, Zero}, 2'b10);
      count_dones(12, n_done);
      check_eq("mul_no_extra_done", n_done, 0);
      check_eq("mul_hold_y", Y, 8'h01);

      // Abort a MUL during its fourth iteration.
      start_op(5'h10, 8'h12, 8'h34, 1'b0, 1'b0);
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      #1;
      check_eq("abort_y", {Y_High, Y}, 0);
      check_eq("abort_flags", {Busy, Done, Carry, Zero, Div_Zero}, 0);
      @(negedge Clk);
      Reset = 1'b0;
      count_dones(12, n_done);
      check_eq("abort_no_done", n_done, 0);
      run_op(5'h02, 8'h05, 8'h03, 1'b0, 1'b0, lat);
      check_eq("post_abort_lat", lat, 1);
      check_eq("post_abort_y", Y, 8'h08);

      run_op(5'h0A, 8'h81, 8'h00, 1'b0, 1'b0, lat);
      check_eq("rlc", {Carry, Y}, {1'b1, 8'h02});
      run_op(5'h0B, 8'h81, 8'h00, 1'b0, 1'b0, lat);
      check_eq("rrc", {Carry, Y}, {1'b1, 8'h40});
      run_op(5'h0D, 8'h81, 8'h00, 1'b0, 1'b0, lat);
      check_eq("ror", {Carry, Y}, {1'b1, 8'hC0});
      run_op(5'h00, 8'h81, 8'h00, 1'b0, 1'b1, lat);
      check_eq("pass", {Zero, Y}, {1'b1, 8'h81});
      run_op(5'h04, 8'h01, 8'h00, 1'b0, 1'b0, lat);
      check_eq("neg", {Carry, Zero, Y}, {2'b10, 8'hFF});
      run_op(5'h0F, 8'h02, 8'h00, 1'b1, 1'b0, lat);
      check_eq("shr", {Carry, Zero, Y}, {2'b10, 8'h81});
      run_op(5'h1F, 8'h00, 8'h55, 1'b0, 1'b0, lat);
      check_eq("reserved", {Zero, Y}, {1'b0, 8'h00});

`ifdef CPU_ARITH_SEQ_DIV_EN
      run_op(5'h11, 8'd200, 8'd7, 1'b1, 1'b0, lat);
      check_eq("div_lat", lat, 9);
      check_eq("div_q_r", {Y_High, Y}, {8'h04, 8'h1C});
      check_eq("div_flags", {Carry, Zero, Div_Zero}, 3'b000);
      run_op(5'h11, 8'h35, 8'h00, 1'b1, 1'b1, lat);
      check_eq("div0_lat", lat, 1);
      check_eq("div0_q_r", {Y_High, Y}, {8'h35, 8'hFF});
      check_eq("div0_flags", {Carry, Zero, Div_Zero}, 3'b001);
      run_op(5'h03, 8'hF0, 8'h0F, 1'b0, 1'b0, lat);
      check_eq("dz_clear", {Zero, Div_Zero, Y}, {2'b10, 8'h00});
`else
      run_op(5'h11, 8'h35, 8'h07, 1'b0, 1'b1, lat);
      check_eq("t11_lat", lat, 1);
      check_eq("t11_pass", {Y_High, Y}, {8'h00, 8'h35});
      check_eq("t11_flags", {Zero, Div_Zero}, 2'b10);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
